// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port RAM with one write port and one read port, byte
// enables, write-first read-during-write, and an optional output register.
// After every reset the RAM can sweep itself to zero before accepting traffic.
//
// State table:
//   ST_CLEAR | post-reset zero sweep (or a single-cycle pass when CLEAR_=0);
//            | user we/re are ignored and ready=0
//   ST_RUN   | normal operation; ready=1
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   ready  - high when user reads and writes are accepted
//   we     - write enable
//   waddr  - write address
//   din    - write data
//   be     - byte enables, be[i] gates din[8i+7:8i]
//   re     - read enable
//   raddr  - read address
//   dout   - read data, held until the next read completes
//   dvalid - one-cycle strobe per completed read (latency 1 + OREG_)
module bram_sdp #(
  parameter int ADDR_  = 8,
  parameter int DATA_  = 8,
  parameter int OREG_  = 0,
  parameter int CLEAR_ = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic                 we,
  input  logic [ADDR_-1:0]     waddr,
  input  logic [DATA_-1:0]     din,
  input  logic [DATA_/8-1:0]   be,
  input  logic                 re,
  input  logic [ADDR_-1:0]     raddr,
  output logic [DATA_-1:0]     dout,
  output logic                 dvalid
);

  localparam int BE_    = DATA_ / 8;
  localparam int DEPTH_ = 1 << ADDR_;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_-1:0]   cnt_q, cnt_d;

  // read pipeline: stage 1 is the array read, stage 2 the optional output register
  logic               v1_q, v1_d;
  logic [DATA_-1:0]   d1_q, d1_d;
  logic               v2_q, v2_d;
  logic [DATA_-1:0]   d2_q, d2_d;

  // write port, shared between the clear sweep and user writes
  logic [BE_-1:0]     mem_wbe;
  logic [ADDR_-1:0]   mem_addr;
  logic [DATA_-1:0]   mem_wdata;

  logic               rd_en;
  logic [DATA_-1:0]   rd_word;

  // contents are deliberately not reset; zeroing happens only through the sweep
  logic [DATA_-1:0]   mem [DEPTH_];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_wbe   = '0;
    mem_addr  = waddr;
    mem_wdata = din;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ != 0) begin
          mem_wbe   = '1;
          mem_addr  = cnt_q;
          mem_wdata = '0;
          cnt_d     = cnt_q + 1'b1;
          // last word is written on the same edge that enters RUN
          if (cnt_q == '1) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (we) mem_wbe = be;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Same-address read during a write returns the merged word: enabled lanes
  // from din, remaining lanes from the current contents.
  always_comb begin
    rd_en   = (state_q == ST_RUN) && re;
    rd_word = mem[raddr];
    if (rd_en && we && (waddr == raddr)) begin
      for (int i = 0; i < BE_; i++) begin
        if (be[i]) rd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
    v1_d = rd_en;
    d1_d = rd_en ? rd_word : d1_q;
    v2_d = v1_q;
    d2_d = v1_q ? d1_q : d2_q;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_; i++) begin
      if (mem_wbe[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      d1_q    <= '0;
      v2_q    <= 1'b0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      v2_q    <= v2_d;
      d2_q    <= d2_d;
    end
  end

  assign ready  = (state_q == ST_RUN);
  assign dvalid = (OREG_ != 0) ? v2_q : v1_q;
  assign dout   = (OREG_ != 0) ? d2_q : d1_q;

endmodule

// File: tb/tb_bram_sdp.sv
module tb_bram_sdp;

  logic clk;
  logic rst_n;

  // dut_a: ADDR_=4, DATA_=16, OREG_=0, CLEAR_=1
  logic        a_ready, a_we, a_re, a_dvalid;
  logic [3:0]  a_waddr, a_raddr;
  logic [15:0] a_din, a_dout;
  logic [1:0]  a_be;

  // dut_b: ADDR_=4, DATA_=8, OREG_=1, CLEAR_=1
  logic        b_ready, b_we, b_re, b_dvalid;
  logic [3:0]  b_waddr, b_raddr;
  logic [7:0]  b_din, b_dout;
  logic [0:0]  b_be;

  // dut_c: ADDR_=4, DATA_=8, OREG_=0, CLEAR_=0
  logic        c_ready, c_dvalid;
  logic [7:0]  c_dout;

  int checks = 0;
  int errors = 0;

  bram_sdp #(.ADDR_(4), .DATA_(16), .OREG_(0), .CLEAR_(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ready(a_ready), .we(a_we), .waddr(a_waddr),
    .din(a_din), .be(a_be), .re(a_re), .raddr(a_raddr), .dout(a_dout),
    .dvalid(a_dvalid)
  );

  bram_sdp #(.ADDR_(4), .DATA_(8), .OREG_(1), .CLEAR_(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(b_ready), .we(b_we), .waddr(b_waddr),
    .din(b_din), .be(b_be), .re(b_re), .raddr(b_raddr), .dout(b_dout),
    .dvalid(b_dvalid)
  );

  bram_sdp #(.ADDR_(4), .DATA_(8), .OREG_(0), .CLEAR_(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ready(c_ready), .we(1'b0), .waddr(4'd0),
    .din(8'd0), .be(1'b0), .re(1'b0), .raddr(4'd0), .dout(c_dout),
    .dvalid(c_dvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts rising edges after reset release until each CLEAR_=1/0 instance is ready,
  // and notes any dvalid seen while not ready.
  task automatic wait_ready(output int ea, output int eb, output int ec, output logic saw_dv);
    ea = 0; eb = 0; ec = 0; saw_dv = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!a_ready && a_dvalid) saw_dv = 1'b1;
      if (!b_ready && b_dvalid) saw_dv = 1'b1;
      if (a_ready && ea == 0) ea = n;
      if (b_ready && eb == 0) eb = n;
      if (c_ready && ec == 0) ec = n;
      if (ea != 0 && eb != 0 && ec != 0) break;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a_ready"},  a_ready,  1'b0);
    chk({tag, "_a_dvalid"}, a_dvalid, 1'b0);
    chk({tag, "_a_dout"},   a_dout,   16'h0);
    chk({tag, "_b_ready"},  b_ready,  1'b0);
    chk({tag, "_b_dvalid"}, b_dvalid, 1'b0);
    chk({tag, "_b_dout"},   b_dout,   8'h0);
  endtask

  int ea, eb, ec;
  logic saw;

  initial begin
    vecs[0]  = '{1'b1, 4'd5,  16'h1234, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 4'd5,  16'hABCD, 2'b10, 1'b1, 4'd5,  1'b1, 16'hAB34};
    vecs[2]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  1'b1, 16'hAB34};
    vecs[3]  = '{1'b1, 4'd3,  16'h00A5, 2'b11, 1'b1, 4'd7,  1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h00A5};
    vecs[5]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 4'd0,  1'b0, 16'h00A5};
    vecs[6]  = '{1'b1, 4'd3,  16'hFFFF, 2'b00, 1'b1, 4'd3,  1'b1, 16'h00A5};
    vecs[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h00A5};
    vecs[8]  = '{1'b1, 4'd15, 16'h5A5A, 2'b01, 1'b1, 4'd15, 1'b1, 16'h005A};
    vecs[9]  = '{1'b1, 4'd0,  16'h1111, 2'b11, 1'b1, 4'd15, 1'b1, 16'h005A};
    vecs[10] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd0,  1'b1, 16'h1111};
    vecs[11] = '{1'b1, 4'd15, 16'hC3C3, 2'b11, 1'b0, 4'd0,  1'b0, 16'h1111};
    vecs[12] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd15, 1'b1, 16'hC3C3};

    rst_n = 1'b0;
    a_we = 0; a_waddr = 0; a_din = 0; a_be = 0; a_re = 0; a_raddr = 0;
    b_we = 0; b_waddr = 0; b_din = 0; b_be = 0; b_re = 0; b_raddr = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    chk("rst_c_ready", c_ready, 1'b0);

    // user traffic during the sweep must be ignored
    a_we = 1; a_waddr = 4'd2; a_din = 16'h00FF; a_be = 2'b11; a_re = 1; a_raddr = 4'd2;
    @(negedge clk) rst_n = 1'b1;
    wait_ready(ea, eb, ec, saw);
    a_we = 0; a_re = 0; a_be = 0;
    chk("clear_edges_a", ea, 16);
    chk("clear_edges_b", eb, 16);
    chk("noclear_edges_c", ec, 1);
    chk("clear_no_dvalid", saw, 1'b0);

    for (int k = 0; k < 16; k++) begin
      a_re = 1; a_raddr = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("clr_rd_v_%0d", k), a_dvalid, 1'b1);
      chk($sformatf("clr_rd_d_%0d", k), a_dout, 16'h0);
    end
    a_re = 0;

    for (int i = 0; i < 13; i++) begin
      a_we = vecs[i].we; a_waddr = vecs[i].waddr; a_din = vecs[i].din;
      a_be = vecs[i].be; a_re = vecs[i].re; a_raddr = vecs[i].raddr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_dvalid", i), a_dvalid, vecs[i].exp_v);
      chk($sformatf("vec%0d_dout", i), a_dout, vecs[i].exp_d);
    end
    a_we = 0; a_re = 0; a_be = 0;

    // OREG_=1 latency: two edges
    b_we = 1; b_waddr = 4'd3; b_din = 8'hA5; b_be = 1'b1;
    @(posedge clk); #1;
    b_we = 0; b_re = 1; b_raddr = 4'd3;
    @(posedge clk); #1;
    b_re = 0;
    chk("oreg_lat1_dvalid", b_dvalid, 1'b0);
    @(posedge clk); #1;
    chk("oreg_lat2_dvalid", b_dvalid, 1'b1);
    chk("oreg_lat2_dout", b_dout, 8'hA5);
    @(posedge clk); #1;
    chk("oreg_hold_dvalid", b_dvalid, 1'b0);
    chk("oreg_hold_dout", b_dout, 8'hA5);

    // fill addr k = k, then stream 16 reads back to back
    for (int k = 0; k < 16; k++) begin
      b_we = 1; b_waddr = 4'(k); b_din = 8'(k); b_be = 1'b1;
      @(posedge clk); #1;
    end
    b_we = 0;
    for (int c = 0; c < 18; c++) begin
      b_re = (c < 16); b_raddr = 4'(c);
      @(posedge clk); #1;
      if (c >= 1 && c <= 16) begin
        chk($sformatf("stream_v_%0d", c), b_dvalid, 1'b1);
        chk($sformatf("stream_d_%0d", c), b_dout, 8'(c - 1));
      end else begin
        chk($sformatf("stream_v_%0d", c), b_dvalid, 1'b0);
      end
    end
    b_re = 0;
    chk("stream_hold_dout", b_dout, 8'd15);

    // reset with a read in flight in dut_b and non-zero dout in both
    b_re = 1; b_raddr = 4'd5;
    @(posedge clk); #2;
    b_re = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrd");
    @(negedge clk) rst_n = 1'b1;
    wait_ready(ea, eb, ec, saw);
    chk("midrd_edges_a", ea, 16);
    chk("midrd_edges_b", eb, 16);
    chk("midrd_no_dvalid", saw, 1'b0);

    // reset at cnt=7: sweep must restart from address 0
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midclr");
    @(negedge clk) rst_n = 1'b1;
    wait_ready(ea, eb, ec, saw);
    chk("midclr_edges_a", ea, 16);
    chk("midclr_edges_b", eb, 16);
    chk("midclr_edges_c", ec, 1);

    // memory is not reset directly, but the sweep zeroed it again
    a_re = 1; a_raddr = 4'd5;
    @(posedge clk); #1;
    a_re = 0;
    chk("post_sweep_dvalid", a_dvalid, 1'b1);
    chk("post_sweep_dout", a_dout, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
